// File: rtl/exc_collector_pkg.sv
// Shared definitions for the exception collector: exception-vector bit
// positions, memory access-size encodings and the redirect FSM states.
package exc_collector_pkg;

  localparam int EXC_ADEL_IF = 31;
  localparam int EXC_RI      = 30;
  localparam int EXC_OV      = 29;
  localparam int EXC_TR      = 28;
  localparam int EXC_SYS     = 27;
  localparam int EXC_ADEL_LD = 26;
  localparam int EXC_ADES_ST = 25;
  localparam int EXC_INT     = 1;
  localparam int EXC_ERET    = 0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } redir_state_e;

  // True when the low address bits violate the natural alignment of the access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    is_misaligned = ((size == SIZE_HALF) && addr_lo[0]) ||
                    ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/exc_align_check.sv
// Combinational alignment check for the EX-stage memory access; flags a
// misaligned load or store.
module exc_align_check
  import exc_collector_pkg::*;
(
  input  logic       mem_rd_i,
  input  logic       mem_wr_i,
  input  logic [1:0] mem_size_i,
  input  logic [1:0] addr_lo_i,
  output logic       load_fault_o,
  output logic       store_fault_o
);

  logic misaligned;

  assign misaligned    = is_misaligned(mem_size_i, addr_lo_i);
  assign load_fault_o  = mem_rd_i & misaligned;
  assign store_fault_o = mem_wr_i & misaligned;

endmodule

// File: rtl/exc_collector.sv
// Carries per-stage exception flags through ID/EX/MEM to CP0 and turns the CP0
// flush pulse into a pipeline flush plus a valid/ready redirect to fetch.
// Optional interrupt sampling on bit 1 is enabled by defining EXC_INT_SAMPLE_EN.
module exc_collector
  import exc_collector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] if_pc_i,
  input  logic              if_valid_i,
  input  logic              id_ri_i,
  input  logic              id_sys_i,
  input  logic              id_eret_i,
  input  logic              id_branch_i,
  input  logic              ex_ov_i,
  input  logic              ex_trap_i,
  input  logic              ex_mem_rd_i,
  input  logic              ex_mem_wr_i,
  input  logic [1:0]        ex_mem_size_i,
  input  logic [DATA_W-1:0] ex_mem_addr_i,
  input  logic              cp0_flush_i,
  input  logic [DATA_W-1:0] cp0_return_pc_i,
  output logic [EXC_W-1:0]  exception_type_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] exception_addr_o,
  output logic              in_delayslot_o,
  output logic              flush_pipe_o,
  output logic              redirect_valid_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  input  logic              redirect_ready_i
`ifdef EXC_INT_SAMPLE_EN
  ,
  input  logic [5:0]        int_i,
  input  logic [7:0]        status_im_i,
  input  logic              status_ie_i,
  input  logic              status_exl_i
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [EXC_W-1:0]  exc;
    logic              ds;
  } stage_t;

  stage_t            id_q, id_d, ex_q, ex_d, mem_q, mem_d;
  logic [DATA_W-1:0] mem_badaddr_q, mem_badaddr_d;
  logic              ds_pending_q, ds_pending_d;
  redir_state_e      state_q;
  logic [DATA_W-1:0] ret_pc_q;

  logic              flush;
  logic              ds_now;
  logic              ld_fault, st_fault;
  logic [EXC_W-1:0]  id_flags, ex_flags, int_vec, mem_exc;

  // Flush covers the pulse cycle itself and every cycle spent waiting in REDIR.
  assign flush        = cp0_flush_i | (state_q == REDIR);
  assign flush_pipe_o = flush;

  exc_align_check u_align (
    .mem_rd_i      (ex_mem_rd_i),
    .mem_wr_i      (ex_mem_wr_i),
    .mem_size_i    (ex_mem_size_i),
    .addr_lo_i     (ex_mem_addr_i[1:0]),
    .load_fault_o  (ld_fault),
    .store_fault_o (st_fault)
  );

  always_comb begin
    id_flags            = '0;
    id_flags[EXC_RI]    = id_ri_i;
    id_flags[EXC_SYS]   = id_sys_i;
    id_flags[EXC_ERET]  = id_eret_i;
    if (!id_q.valid) id_flags = '0;

    ex_flags              = '0;
    ex_flags[EXC_OV]      = ex_ov_i;
    ex_flags[EXC_TR]      = ex_trap_i;
    ex_flags[EXC_ADEL_LD] = ld_fault;
    ex_flags[EXC_ADES_ST] = st_fault;
    if (!ex_q.valid) ex_flags = '0;
  end

  // A branch currently in ID makes the next fetched instruction its delay slot,
  // even when that instruction enters ID on the very edge the branch leaves.
  assign ds_now = ds_pending_q | (id_q.valid & id_branch_i);

  always_comb begin
    id_d          = id_q;
    ex_d          = ex_q;
    mem_d         = mem_q;
    mem_badaddr_d = mem_badaddr_q;
    ds_pending_d  = ds_pending_q;
    if (flush) begin
      id_d.valid   = 1'b0;
      id_d.exc     = '0;
      ex_d.valid   = 1'b0;
      ex_d.exc     = '0;
      mem_d.valid  = 1'b0;
      mem_d.exc    = '0;
      ds_pending_d = 1'b0;
    end else if (!stall_i) begin
      id_d.valid            = if_valid_i;
      id_d.pc               = if_pc_i;
      id_d.exc              = '0;
      id_d.exc[EXC_ADEL_IF] = if_valid_i & (if_pc_i[1:0] != 2'b00);
      id_d.ds               = if_valid_i & ds_now;
      ds_pending_d          = if_valid_i ? 1'b0 : ds_now;

      ex_d     = id_q;
      ex_d.exc = id_q.exc | id_flags;

      mem_d         = ex_q;
      mem_d.exc     = ex_q.exc | ex_flags;
      mem_badaddr_d = ex_mem_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q          <= '0;
      ex_q          <= '0;
      mem_q         <= '0;
      mem_badaddr_q <= '0;
      ds_pending_q  <= 1'b0;
    end else begin
      id_q          <= id_d;
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      mem_badaddr_q <= mem_badaddr_d;
      ds_pending_q  <= ds_pending_d;
    end
  end

`ifdef EXC_INT_SAMPLE_EN
  logic [5:0] int_sync1_q, int_sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      int_sync1_q <= '0;
      int_sync2_q <= '0;
    end else begin
      int_sync1_q <= int_i;
      int_sync2_q <= int_sync1_q;
    end
  end

  always_comb begin
    int_vec          = '0;
    int_vec[EXC_INT] = status_ie_i & ~status_exl_i & (|(int_sync2_q & status_im_i[7:2]));
  end
`else
  assign int_vec = '0;
`endif

  assign mem_exc          = mem_q.exc | int_vec;
  assign exception_type_o = mem_q.valid ? mem_exc : '0;
  assign pc_o             = mem_q.valid ? mem_q.pc : '0;
  assign in_delayslot_o   = mem_q.valid & mem_q.ds;

  always_comb begin
    exception_addr_o = '0;
    if (mem_q.valid) begin
      if (mem_q.exc[EXC_ADEL_LD] || mem_q.exc[EXC_ADES_ST]) exception_addr_o = mem_badaddr_q;
      else if (mem_q.exc[EXC_ADEL_IF])                       exception_addr_o = mem_q.pc;
    end
  end

  // A new flush pulse while already redirecting retargets the pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ret_pc_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (cp0_flush_i) begin
            ret_pc_q <= cp0_return_pc_i;
            state_q  <= REDIR;
          end
        end
        REDIR: begin
          if (cp0_flush_i)           ret_pc_q <= cp0_return_pc_i;
          else if (redirect_ready_i) state_q  <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign redirect_valid_o = (state_q == REDIR);
  assign redirect_pc_o    = (state_q == REDIR) ? ret_pc_q : '0;

endmodule
